// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern generator: fv/lv/hsync/vsync/de plus a
// channel-serialised pixel stream whose pattern and solid colour are latched per frame.
module video_pattern_gen #(
    parameter int H_ACTIVE      = 1920,
    parameter int H_TOTAL       = 2200,
    parameter int V_ACTIVE      = 1080,
    parameter int V_TOTAL       = 1125,
    parameter int H_FRONT_PORCH = 88,
    parameter int H_SYNCH       = 44,
    parameter int V_FRONT_PORCH = 4,
    parameter int V_SYNCH       = 5,
    parameter int DW            = 8,
    parameter int NCH           = 3,
    parameter int BAR_W         = 80,
    parameter int CHECK_LOG2    = 3,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1
) (
    input  logic              pixclk,
    input  logic              rstn,
    input  logic [2:0]        mode,
    input  logic [3*DW-1:0]   solid_rgb,
    output logic              fv,
    output logic              lv,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [DW-1:0]     data,
    output logic              sof,
    output logic [7:0]        frame_cnt
);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int XW      = $clog2(H_ACTIVE + 1);
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int WW      = (DW > 1) ? $clog2(DW) : 1;
    localparam int V_START = V_TOTAL - V_ACTIVE;
    localparam int BAND1   = V_ACTIVE / 3;
    localparam int BAND2   = 2 * V_ACTIVE / 3;
    localparam bit DW_POW2 = (DW & (DW - 1)) == 0;
    localparam logic [DW-1:0] ONE = DW'(1);

    typedef enum logic [2:0] {
        MODE_BARS  = 3'd0,
        MODE_BANDS = 3'd1,
        MODE_SOLID = 3'd2,
        MODE_WALK  = 3'd3,
        MODE_CHECK = 3'd4,
        MODE_RAMP  = 3'd5
    } mode_e;

    // {R,G,B} on/off masks: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_MASK [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                            3'b101, 3'b100, 3'b001, 3'b000};

    function automatic logic [3*DW-1:0] expand(input logic [2:0] m);
        return {{DW{m[2]}}, {DW{m[1]}}, {DW{m[0]}}};
    endfunction

    function automatic logic [DW-1:0] chan(input logic [3*DW-1:0] rgb, input logic [CW-1:0] c);
        if (int'(c) == 0)      return rgb[3*DW-1:2*DW];
        else if (int'(c) == 1) return rgb[2*DW-1:DW];
        else                   return rgb[DW-1:0];
    endfunction

    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [XW-1:0]   x_q, x_d;
    logic [2:0]      bar_q, bar_d;
    logic [BW-1:0]   bar_pix_q, bar_pix_d;
    logic [WW-1:0]   wk_q, wk_d;
    logic [2:0]      mode_q, mode_d;
    logic [3*DW-1:0] solid_q, solid_d;
    logic            first_q, first_d;
    logic            fv_q, fv_d, lv_q, lv_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic            de_q, de_d, sof_q, sof_d;
    logic [DW-1:0]   data_q, data_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    int              h, v, x, y;
    logic            frame_line, active, frame_start, pix_last;
    logic [2:0]      band_mask;
    logic [WW-1:0]   walk_idx;
    logic [DW-1:0]   pix;

    // NOTE: combinational next-state logic uses blocking assignments with every
    // variable defaulted first, so no path can leave a latch behind.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        ch_d        = ch_q;
        x_d         = x_q;
        bar_d       = bar_q;
        bar_pix_d   = bar_pix_q;
        wk_d        = wk_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        first_d     = first_q;
        frame_cnt_d = frame_cnt_q;

        h           = int'(h_cnt_q);
        v           = int'(v_cnt_q);
        x           = int'(x_q);
        y           = v - V_START;
        frame_line  = v >= V_START;
        active      = frame_line && (h < H_ACTIVE);
        frame_start = (h == 0) && (v == 0);
        pix_last    = ch_q == CW'(NCH - 1);

        if (h == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (v == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        if (!active) begin
            ch_d      = '0;
            x_d       = '0;
            bar_d     = '0;
            bar_pix_d = '0;
            wk_d      = '0;
        end else if (pix_last) begin
            ch_d = '0;
            x_d  = x_q + 1'b1;
            if (bar_pix_q == BW'(BAR_W - 1)) begin
                bar_pix_d = '0;
                if (bar_q != 3'd7) bar_d = bar_q + 1'b1;
            end else begin
                bar_pix_d = bar_pix_q + 1'b1;
            end
            if (!DW_POW2) wk_d = (wk_q == WW'(DW - 1)) ? '0 : wk_q + 1'b1;
        end else begin
            ch_d = ch_q + 1'b1;
        end

        if (frame_start) begin
            mode_d      = mode;
            solid_d     = solid_rgb;
            first_d     = 1'b0;
            frame_cnt_d = first_q ? frame_cnt_q : frame_cnt_q + 1'b1;
        end

        band_mask = (y < BAND1) ? 3'b001 : (y < BAND2) ? 3'b010 : 3'b100;
        walk_idx  = DW_POW2 ? WW'(x % DW) : wk_q;
        case (mode_q)
            MODE_BARS:  pix = chan(expand(BAR_MASK[bar_q]), ch_q);
            MODE_BANDS: pix = chan(expand(band_mask), ch_q);
            MODE_SOLID: pix = chan(solid_q, ch_q);
            MODE_WALK:  pix = ONE << walk_idx;
            MODE_CHECK: pix = (((x >> CHECK_LOG2) ^ (y >> CHECK_LOG2)) & 1) != 0 ? '1 : '0;
            MODE_RAMP:  pix = DW'(x + int'(frame_cnt_q));
            default:    pix = '0;
        endcase

        fv_d    = frame_line;
        lv_d    = active;
        de_d    = active && (ch_q == '0);
        data_d  = active ? pix : '0;
        sof_d   = frame_start;
        hsync_d = (frame_line && h >= H_FRONT_PORCH && h < H_FRONT_PORCH + H_SYNCH)
                  ? HS_POL : ~HS_POL;
        vsync_d = (v >= V_FRONT_PORCH && v < V_FRONT_PORCH + V_SYNCH) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge pixclk or negedge rstn) begin
        if (!rstn) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            ch_q        <= '0;
            x_q         <= '0;
            bar_q       <= '0;
            bar_pix_q   <= '0;
            wk_q        <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            first_q     <= 1'b1;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            de_q        <= 1'b0;
            data_q      <= '0;
            sof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            ch_q        <= ch_d;
            x_q         <= x_d;
            bar_q       <= bar_d;
            bar_pix_q   <= bar_pix_d;
            wk_q        <= wk_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            first_q     <= first_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            data_q      <= data_d;
            sof_q       <= sof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign fv        = fv_q;
    assign lv        = lv_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign data      = data_q;
    assign sof       = sof_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a small positive-sync instance and a wider negative-sync
// instance, with pixel expectations queued per frame and popped as lv samples arrive.
module tb_video_pattern_gen;
    logic        pixclk = 1'b0;
    logic        rstn;
    logic [2:0]  mode_s, mode_w;
    logic [23:0] solid_s, solid_w;
    logic        fv_s, lv_s, hsync_s, vsync_s, de_s, sof_s;
    logic        fv_w, lv_w, hsync_w, vsync_w, de_w, sof_w;
    logic [7:0]  data_s, data_w, frame_cnt_s, frame_cnt_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       de;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 pixclk = ~pixclk;

    video_pattern_gen #(
        .H_ACTIVE(12), .H_TOTAL(16), .V_ACTIVE(4), .V_TOTAL(6),
        .H_FRONT_PORCH(13), .H_SYNCH(2), .V_FRONT_PORCH(1), .V_SYNCH(1),
        .DW(8), .NCH(3), .BAR_W(1), .CHECK_LOG2(3), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .pixclk(pixclk), .rstn(rstn), .mode(mode_s), .solid_rgb(solid_s),
        .fv(fv_s), .lv(lv_s), .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
        .data(data_s), .sof(sof_s), .frame_cnt(frame_cnt_s)
    );

    video_pattern_gen #(
        .H_ACTIVE(30), .H_TOTAL(40), .V_ACTIVE(4), .V_TOTAL(6),
        .H_FRONT_PORCH(32), .H_SYNCH(4), .V_FRONT_PORCH(0), .V_SYNCH(2),
        .DW(8), .NCH(3), .BAR_W(1), .CHECK_LOG2(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_w (
        .pixclk(pixclk), .rstn(rstn), .mode(mode_w), .solid_rgb(solid_w),
        .fv(fv_w), .lv(lv_w), .hsync(hsync_w), .vsync(vsync_w), .de(de_w),
        .data(data_w), .sof(sof_w), .frame_cnt(frame_cnt_w)
    );

    // Reference pixel model, written from the pattern definitions rather than the RTL.
    function automatic logic [7:0] ref_byte(input int m, input logic [23:0] solid, input int x,
                                            input int c, input int y, input int fc,
                                            input int va, input int clog);
        logic [23:0] rgb;
        int          sh;
        sh = 8 * (2 - c);
        case (m)
            0: begin rgb = BARS[(x > 7) ? 7 : x]; return 8'((rgb >> sh) & 24'hFF); end
            1: begin
                rgb = (y < va / 3) ? 24'h0000FF : (y < 2 * va / 3) ? 24'h00FF00 : 24'hFF0000;
                return 8'((rgb >> sh) & 24'hFF);
            end
            2: return 8'((solid >> sh) & 24'hFF);
            3: return 8'(1 << (x % 8));
            4: return ((((x >> clog) ^ (y >> clog)) & 1) != 0) ? 8'hFF : 8'h00;
            5: return 8'(x + fc);
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_frame(input bit wide, input int m, input logic [23:0] solid, input int fc);
        int   ha;
        exp_t e;
        ha = wide ? 30 : 12;
        for (int y = 0; y < 4; y++) begin
            for (int h = 0; h < ha; h++) begin
                e.data = ref_byte(m, solid, h / 3, h % 3, y, fc, 4, wide ? 1 : 3);
                e.de   = (h % 3) == 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Waits for the next sof of the selected instance, then pops one expectation per lv
    // sample; at pop index change_at the small instance is switched to solid 123456h.
    task automatic consume_frame(input bit wide, input string tag, input int change_at);
        int   budget;
        int   idx;
        exp_t e;
        logic lv_o, de_o;
        logic [7:0] d_o;
        budget = 0;
        idx    = 0;
        @(negedge pixclk);
        while (!(wide ? sof_w : sof_s) && budget < 800) begin
            @(negedge pixclk);
            budget++;
        end
        while (exp_q.size() > 0 && budget < 800) begin
            @(negedge pixclk);
            budget++;
            lv_o = wide ? lv_w : lv_s;
            de_o = wide ? de_w : de_s;
            d_o  = wide ? data_w : data_s;
            if (lv_o) begin
                e = exp_q.pop_front();
                checks++;
                if (d_o !== e.data || de_o !== e.de) begin
                    errors++;
                    $display("FAIL %s pixel %0d: data=%h de=%b, expected data=%h de=%b",
                             tag, idx, d_o, de_o, e.data, e.de);
                end
                idx++;
                if (idx == change_at) begin
                    mode_s  = 3'd2;
                    solid_s = 24'h123456;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d expected pixels never arrived", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int cyc, fv_cnt, lv_run, de_cnt;
        bit first_line;
        rstn = 1'b0;
        repeat (3) @(negedge pixclk);
        checks++;
        if ({fv_s, lv_s, hsync_s, vsync_s, de_s, sof_s} !== 6'b000000 || data_s !== 8'h00
            || frame_cnt_s !== 8'h00) begin
            errors++;
            $display("FAIL reset_small: fv lv hs vs de sof=%b data=%h fc=%h, expected 000000 00 00",
                     {fv_s, lv_s, hsync_s, vsync_s, de_s, sof_s}, data_s, frame_cnt_s);
        end
        checks++;
        if ({fv_w, lv_w, hsync_w, vsync_w, de_w, sof_w} !== 6'b001100 || data_w !== 8'h00) begin
            errors++;
            $display("FAIL reset_wide: fv lv hs vs de sof=%b data=%h, expected 001100 00",
                     {fv_w, lv_w, hsync_w, vsync_w, de_w, sof_w}, data_w);
        end
        // Release on a negedge, counted as cycle 1; line 2 plus one register stage puts
        // the first lv sample in cycle 34.
        rstn = 1'b1;
        cyc  = 1;
        while (!lv_s && cyc < 100) begin
            @(negedge pixclk);
            cyc++;
        end
        checks++;
        if (cyc != 34) begin
            errors++;
            $display("FAIL lv_latency: first lv in cycle %0d, expected 34", cyc);
        end
        fv_cnt = fv_s ? 1 : 0;
        lv_run = 1;
        de_cnt = de_s ? 1 : 0;
        first_line = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge pixclk);
            if (first_line && lv_s) begin
                lv_run++;
                if (de_s) de_cnt++;
            end else begin
                first_line = 1'b0;
            end
            if (fv_s) fv_cnt++;
            else break;
        end
        checks++;
        if (lv_run != 12) begin
            errors++;
            $display("FAIL lv_width: %0d clocks, expected 12", lv_run);
        end
        checks++;
        if (de_cnt != 4) begin
            errors++;
            $display("FAIL de_per_line: %0d pulses, expected 4", de_cnt);
        end
        checks++;
        if (fv_cnt != 64) begin
            errors++;
            $display("FAIL fv_width: %0d clocks, expected 64", fv_cnt);
        end
    endtask

    task automatic test_bars();
        push_frame(1'b0, 0, 24'h0, 0);
        consume_frame(1'b0, "bars", -1);
    endtask

    task automatic test_walk();
        mode_w = 3'd3;
        push_frame(1'b1, 3, 24'h0, 0);
        consume_frame(1'b1, "walk", -1);
    endtask

    task automatic test_checker();
        mode_w = 3'd4;
        push_frame(1'b1, 4, 24'h0, 0);
        consume_frame(1'b1, "checker", -1);
    endtask

    task automatic test_bands();
        mode_s = 3'd1;
        push_frame(1'b0, 1, 24'h0, 0);
        consume_frame(1'b0, "bands", -1);
    endtask

    task automatic test_mode_change();
        int gap;
        mode_s  = 3'd0;
        solid_s = 24'h000000;
        push_frame(1'b0, 0, 24'h0, 0);
        consume_frame(1'b0, "mid_frame_bars", 20);
        push_frame(1'b0, 2, 24'h123456, 0);
        consume_frame(1'b0, "solid", -1);
        gap = 0;
        while (!sof_s && gap < 200) begin
            @(negedge pixclk);
            gap++;
        end
        gap = 0;
        do begin
            @(negedge pixclk);
            gap++;
        end while (!sof_s && gap < 200);
        checks++;
        if (gap != 96) begin
            errors++;
            $display("FAIL sof_period: %0d clocks, expected 96", gap);
        end
    endtask

    task automatic test_sync(input bit wide);
        int budget, hs_cnt, vs_cnt, ft, hs_exp, vs_exp;
        ft     = wide ? 240 : 96;
        hs_exp = wide ? 16 : 8;
        vs_exp = wide ? 80 : 16;
        budget = 0;
        @(negedge pixclk);
        while (!(wide ? sof_w : sof_s) && budget < 300) begin
            @(negedge pixclk);
            budget++;
        end
        hs_cnt = 0;
        vs_cnt = 0;
        for (int i = 0; i < ft; i++) begin
            if (i > 0) @(negedge pixclk);
            if (wide ? (hsync_w == 1'b0) : (hsync_s == 1'b1)) hs_cnt++;
            if (wide ? (vsync_w == 1'b0) : (vsync_s == 1'b1)) vs_cnt++;
        end
        checks++;
        if (hs_cnt != hs_exp) begin
            errors++;
            $display("FAIL hsync_active_%s: %0d clocks, expected %0d", wide ? "wide" : "small",
                     hs_cnt, hs_exp);
        end
        checks++;
        if (vs_cnt != vs_exp) begin
            errors++;
            $display("FAIL vsync_active_%s: %0d clocks, expected %0d", wide ? "wide" : "small",
                     vs_cnt, vs_exp);
        end
    endtask

    task automatic test_reset_mid_line();
        int budget;
        budget = 0;
        @(negedge pixclk);
        while (!lv_s && budget < 200) begin
            @(negedge pixclk);
            budget++;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({fv_s, lv_s, hsync_s, vsync_s, de_s, sof_s} !== 6'b000000 || data_s !== 8'h00
            || frame_cnt_s !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_small: fv lv hs vs de sof=%b data=%h fc=%h, expected 000000 00 00",
                     {fv_s, lv_s, hsync_s, vsync_s, de_s, sof_s}, data_s, frame_cnt_s);
        end
        checks++;
        if ({lv_w, hsync_w, vsync_w} !== 3'b011 || frame_cnt_w !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_wide: lv hs vs=%b fc=%h, expected 011 00",
                     {lv_w, hsync_w, vsync_w}, frame_cnt_w);
        end
        mode_s = 3'd5;
        repeat (2) @(negedge pixclk);
        rstn = 1'b1;
    endtask

    task automatic test_ramp();
        for (int f = 0; f < 3; f++) begin
            push_frame(1'b0, 5, 24'h0, f);
            consume_frame(1'b0, "ramp", -1);
            checks++;
            if (frame_cnt_s !== 8'(f)) begin
                errors++;
                $display("FAIL ramp_frame_cnt: %0d, expected %0d", frame_cnt_s, f);
            end
        end
    endtask

    initial begin
        rstn    = 1'b0;
        mode_s  = 3'd0;
        mode_w  = 3'd0;
        solid_s = 24'h0;
        solid_w = 24'h0;
        test_reset();
        test_bars();
        test_walk();
        test_checker();
        test_bands();
        test_mode_change();
        test_sync(1'b0);
        test_sync(1'b1);
        test_reset_mid_line();
        test_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised video timing and test-pattern generator; successor to the fixed three-band colour generator in the display GPU path.
- Produces fv/lv/hsync/vsync/de plus a channel-serialised pixel stream (NCH sub-pixels per pixel, DW bits each) for the LCD serialiser.
- Pattern is selected at runtime and latched per frame: bars, bands, solid colour, walking ones, checkerboard or frame ramp.

Parameters:
- H_ACTIVE, 1920, active clocks per line; must be a multiple of NCH
- H_TOTAL, 2200, clocks per line
- V_ACTIVE, 1080, active lines per frame
- V_TOTAL, 1125, lines per frame
- H_FRONT_PORCH, 88, h_cnt value where hsync starts
- H_SYNCH, 44, hsync width in clocks
- V_FRONT_PORCH, 4, v_cnt value where vsync starts
- V_SYNCH, 5, vsync width in lines
- DW, 8, bits per sub-pixel
- NCH, 3, sub-pixels per pixel (1..3); channel order ch0=R, ch1=G, ch2=B
- BAR_W, 80, pixels per colour bar
- CHECK_LOG2, 3, checker square size = 2^CHECK_LOG2 pixels/lines
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- pixclk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- mode  in  3  pattern select, latched at frame start
- solid_rgb  in  3*DW  solid colour {R,G,B}, latched with mode
- fv  out  1  frame valid
- lv  out  1  line valid (H_ACTIVE clocks per active line)
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  high on the ch0 clock of each pixel
- data  out  DW  sub-pixel value
- sof  out  1  one-clock pulse at frame start
- frame_cnt  out  8  completed frame count, wraps 255->0

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock pixclk.
- Reset values: all outputs 0, except hsync = ~HS_POL and vsync = ~VS_POL. All counters 0, mode_q=0, solid_q=0.
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt==H_TOTAL-1 and wraps after V_TOTAL-1.
- Active region: h_cnt<H_ACTIVE && v_cnt>=V_TOTAL-V_ACTIVE.
- All outputs are registered: one clock after the counter state that produces them. data is aligned with lv and de.
- fv = (v_cnt >= V_TOTAL-V_ACTIVE).
- hsync active while h_cnt is in [H_FRONT_PORCH, H_FRONT_PORCH+H_SYNCH) on an fv line.
- vsync active while v_cnt is in [V_FRONT_PORCH, V_FRONT_PORCH+V_SYNCH), over the full lines.
- Frame start is h_cnt==0 && v_cnt==0. At frame start:
  - mode_q<=mode and solid_q<=solid_rgb; changes mid-frame have no effect on the current frame.
  - sof pulses.
  - frame_cnt increments, except on the first frame after reset.
- Channel counter ch: 0..NCH-1, advances each lv clock, forced to 0 when not active. de = lv && ch==0.
- Pixel x increments after ch==NCH-1 and resets per line. Active line y = v_cnt-(V_TOTAL-V_ACTIVE).
- FS = all-ones in DW bits. chan(c) selects the R, G or B component.
- Mode 0, colour bars:
  - bar index b increments every BAR_W pixels, saturating at 7, reset per line.
  - colours by index 0..7: white, yellow, cyan, green, magenta, red, blue, black (components 0 or FS).
- Mode 1, horizontal bands:
  - y < V_ACTIVE/3: blue.
  - y < 2*V_ACTIVE/3: green.
  - otherwise: red.
  - Thresholds are compile-time constants.
- Mode 2: solid_q component for the current channel.
- Mode 3, walking ones: every channel = 1<<(x mod DW). For DW a power of two, x mod DW is the low bits of x; otherwise it is a wrap counter.
- Mode 4, checkerboard: FS if x[CHECK_LOG2]^y[CHECK_LOG2], else 0, on all channels.
- Mode 5, ramp: every channel = (x + frame_cnt) truncated to DW.
- Modes 6-7: data=0 during active.
- data=0 whenever lv=0.
- Reset mid-frame: immediate return to reset values; the next frame starts from h_cnt=v_cnt=0.

Test Plan:
- Reset, small config (H_ACTIVE=12, H_TOTAL=16, V_ACTIVE=4, V_TOTAL=6, NCH=3, DW=8, BAR_W=1) -> first lv rises 34 clocks after rstn release (line 2 + 1 reg). lv is 12 clocks wide with 4 de pulses. fv is high for 4 lines of 16 clocks.
- Mode 0, same config -> pixels 0..3 give bytes FF,FF,FF / FF,FF,00 / 00,FF,FF / 00,FF,00.
- Mode 3 -> ch0 data per pixel 01,02,04,08. The 9th pixel (wide config) returns to 01.
- Mode change 0->2 with solid_rgb=123456h mid-frame -> the current frame stays bars. The next frame outputs 12,34,56 repeating. sof pulses once per 96 clocks.
- Sync polarity HS_POL=0, VS_POL=0 -> hsync/vsync idle high and low during their windows. The vsync window covers exactly V_SYNCH*H_TOTAL clocks.
- Mode 5 over 3 frames -> pixel0 ch0 = 00, 01, 02. Assert rstn low mid-line -> all outputs go to reset values in the same cycle and frame_cnt=0.
